// File: rtl/quad_step_encoder_if.sv
// rtl/quad_step_encoder_if.sv - encoder pin inputs and counter strobe outputs
interface quad_step_encoder_if #(
    parameter int WIDTH = 5
);
    logic             A_in;
    logic             B_in;
    logic             Index_in;
    logic             Enable;
    logic             Up;
    logic             Down;
    logic             Load;
    logic [WIDTH-1:0] IN;
    logic             Err;
    logic             Err_Sticky;

    modport master (
        output A_in,
        output B_in,
        output Index_in,
        output Enable,
        input  Up,
        input  Down,
        input  Load,
        input  IN,
        input  Err,
        input  Err_Sticky
    );

    modport slave (
        input  A_in,
        input  B_in,
        input  Index_in,
        input  Enable,
        output Up,
        output Down,
        output Load,
        output IN,
        output Err,
        output Err_Sticky
    );
endinterface

// File: rtl/quad_step_encoder.sv
// rtl/quad_step_encoder.sv - quadrature A/B/Index to up/down counter strobes
module quad_step_encoder #(
    parameter int FILTER_LEN  = 3,
    parameter int WIDTH       = 5,
    parameter int INDEX_VALUE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    quad_step_encoder_if.slave   bus
);
    localparam int CW = 4;
    localparam int IW = 5;

    typedef enum logic [0:0] {
        INIT,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    // Bit order in all 3-bit vectors: {A, B, Index}
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    filt;
    logic [2:0]    filt_next;
    logic [2:0]    prev;
    logic [CW-1:0] flt_cnt      [3];
    logic [CW-1:0] flt_cnt_next [3];
    logic [IW-1:0] init_cnt;
    logic [IW-1:0] init_cnt_next;

    logic up_q, down_q, load_q, err_q, sticky_q;
    logic up_n, down_n, load_n, err_n;

    logic [1:0] ab_prev;
    logic [1:0] ab_cur;
    logic [1:0] pos_prev;
    logic [1:0] pos_cur;
    logic       step_fwd;
    logic       step_rev;
    logic       step_bad;
    logic       idx_rise;

    // Position along the forward cycle 00 -> 01 -> 11 -> 10
    function automatic logic [1:0] ab_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   ab_pos = 2'd0;
            2'b01:   ab_pos = 2'd1;
            2'b11:   ab_pos = 2'd2;
            default: ab_pos = 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.A_in, bus.B_in, bus.Index_in};
            sync2 <= sync1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_next[i]    = filt[i];
            flt_cnt_next[i] = '0;
            if (state == INIT) begin
                filt_next[i] = sync2[i];
            end else if (sync2[i] != filt[i]) begin
                if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt_next[i] = sync2[i];
                end else begin
                    flt_cnt_next[i] = flt_cnt[i] + CW'(1);
                end
            end
        end
    end

    // In INIT the reference follows the freshly loaded value so RUN starts with no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            prev <= '0;
            for (int i = 0; i < 3; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            filt <= filt_next;
            prev <= (state == INIT) ? filt_next : filt;
            for (int i = 0; i < 3; i++) begin
                flt_cnt[i] <= flt_cnt_next[i];
            end
        end
    end

    assign ab_prev  = prev[2:1];
    assign ab_cur   = filt[2:1];
    assign pos_prev = ab_pos(ab_prev);
    assign pos_cur  = ab_pos(ab_cur);
    assign step_fwd = (pos_cur == pos_prev + 2'd1);
    assign step_rev = (pos_prev == pos_cur + 2'd1);
    assign step_bad = &(ab_prev ^ ab_cur);
    assign idx_rise = filt[0] & ~prev[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        up_n          = 1'b0;
        down_n        = 1'b0;
        load_n        = 1'b0;
        err_n         = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == IW'(FILTER_LEN + 1)) begin
                    state_next    = RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt + IW'(1);
                end
            end
            RUN: begin
                err_n = step_bad;
                // Index wins; a coincident step is dropped rather than queued
                if (bus.Enable) begin
                    load_n = idx_rise;
                    up_n   = step_fwd & ~idx_rise;
                    down_n = step_rev & ~idx_rise;
                end
            end
            default: begin
                state_next    = INIT;
                init_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            up_q     <= up_n;
            down_q   <= down_n;
            load_q   <= load_n;
            err_q    <= err_n;
            sticky_q <= sticky_q | err_n;
        end
    end

    assign bus.Up         = up_q;
    assign bus.Down       = down_q;
    assign bus.Load       = load_q;
    assign bus.Err        = err_q;
    assign bus.Err_Sticky = sticky_q;
    assign bus.IN         = load_q ? WIDTH'(INDEX_VALUE) : '0;
endmodule
